// File: rtl/mac_operand_feeder.sv
// Serial byte -> {A, B, C} operand assembler in front of the 8-bit MAC register.
// Optional odd-parity checking on each input byte: define MAC_FEEDER_PARITY_EN.
module mac_operand_feeder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
`ifdef MAC_FEEDER_PARITY_EN
    input  logic              in_parity,
    output logic              par_err,
`endif
    input  logic              hold,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] C,
    output logic              op_valid,
    output logic              sync_err,
    output logic [CNT_W-1:0]  triple_cnt
);

    typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_C} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   a_s, b_s;
    logic [3*DATA_W-1:0] pend;
    logic                pend_full;
    logic                acc, par_bad, drain;
    logic                load_a, load_b, load_c, resync;

`ifdef MAC_FEEDER_PARITY_EN
    // odd parity: the XOR over data plus parity bit must be 1
    assign par_bad = ~(^{in_data, in_parity});
`else
    assign par_bad = 1'b0;
`endif

    // A C byte waits only while the previous triple is still undelivered
    assign in_ready = !reset && !(state == WAIT_C && pend_full);
    assign acc      = in_valid && in_ready;
    assign drain    = pend_full && !hold;

    assign load_a = acc && !par_bad && (in_sof || state == WAIT_A);
    assign load_b = acc && !par_bad && !in_sof && state == WAIT_B;
    assign load_c = acc && !par_bad && !in_sof && state == WAIT_C;
    assign resync = acc && !par_bad && in_sof && state != WAIT_A;

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_A;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (acc) begin
            if (par_bad)     state_nxt = WAIT_A;
            else if (in_sof) state_nxt = WAIT_B;
            else begin
                case (state)
                    WAIT_A:  state_nxt = WAIT_B;
                    WAIT_B:  state_nxt = WAIT_C;
                    default: state_nxt = WAIT_A;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_s        <= '0;
            b_s        <= '0;
            pend       <= '0;
            pend_full  <= 1'b0;
            A          <= '0;
            B          <= '0;
            C          <= '0;
            op_valid   <= 1'b0;
            sync_err   <= 1'b0;
            triple_cnt <= '0;
`ifdef MAC_FEEDER_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            op_valid <= drain;
            sync_err <= resync;
`ifdef MAC_FEEDER_PARITY_EN
            par_err  <= acc && par_bad;
`endif
            if (drain) begin
                {A, B, C}  <= pend;
                triple_cnt <= triple_cnt + CNT_W'(1);
            end
            if (acc && par_bad) begin
                a_s <= '0;
                b_s <= '0;
            end else begin
                if (load_a) a_s <= in_data;
                if (load_b) b_s <= in_data;
            end
            // load_c and drain are exclusive: in_ready is low in WAIT_C while pend_full
            if (load_c) begin
                pend      <= {a_s, b_s, in_data};
                pend_full <= 1'b1;
            end else if (drain) begin
                pend_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder: vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_mac_operand_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic        hold = 1'b0;
    logic [7:0]  A, B, C;
    logic        op_valid, sync_err;
    logic [15:0] triple_cnt;
`ifdef MAC_FEEDER_PARITY_EN
    logic        in_parity = 1'b1;
    logic        par_err;
`endif

    mac_operand_feeder #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_sof(in_sof),
`ifdef MAC_FEEDER_PARITY_EN
        .in_parity(in_parity), .par_err(par_err),
`endif
        .hold(hold), .A(A), .B(B), .C(C), .op_valid(op_valid),
        .sync_err(sync_err), .triple_cnt(triple_cnt)
    );

    always #5 clk = ~clk;

    // downstream MAC register: DATA_OUT = A*B + C, one edge after the operands
    logic [15:0] mac_q = '0;
    always @(posedge clk) mac_q <= 16'(A) * 16'(B) + 16'(C);

    int n_chk = 0;
    int n_fail = 0;

    // reference model: bytes of the frame in progress, one pending triple, outputs
    logic [7:0]  m_part[$];
    logic        m_pend_v = 1'b0;
    logic [23:0] m_pend = '0;
    logic [7:0]  m_A = '0, m_B = '0, m_C = '0;
    logic        m_opv = 1'b0, m_serr = 1'b0, m_perr = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        m_rdy;
    logic        bad_par = 1'b0;
    logic        cur_acc, dut_rdy;
    logic [23:0] got_q[$];
    int          serr_cnt, perr_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [7:0] d, input logic v, input logic s,
                        input logic h, input logic r);
        logic bad;
        @(negedge clk);
        in_data = d; in_valid = v; in_sof = s; hold = h; reset = r;
`ifdef MAC_FEEDER_PARITY_EN
        in_parity = bad_par ? ^d : ~^d;
        bad = bad_par;
`else
        bad = 1'b0;
`endif
        #1;
        m_rdy = !r && !(m_part.size() == 2 && m_pend_v);
        dut_rdy = in_ready;
        chk("in_ready", in_ready, m_rdy);
        cur_acc = v && m_rdy;
        @(posedge clk);
        if (r) begin
            m_part.delete();
            m_pend_v = 0; m_A = 0; m_B = 0; m_C = 0;
            m_opv = 0; m_serr = 0; m_perr = 0; m_cnt = 0;
        end else begin
            m_opv = m_pend_v && !h;
            if (m_opv) begin
                {m_A, m_B, m_C} = m_pend;
                m_cnt++;
                m_pend_v = 0;
            end
            m_serr = 0; m_perr = 0;
            if (cur_acc) begin
                if (bad) begin
                    m_part.delete();
                    m_perr = 1;
                end else if (s || m_part.size() == 0) begin
                    m_serr = s && m_part.size() != 0;
                    m_part.delete();
                    m_part.push_back(d);
                end else if (m_part.size() == 1) begin
                    m_part.push_back(d);
                end else begin
                    m_pend = {m_part[0], m_part[1], d};
                    m_pend_v = 1;
                    m_part.delete();
                end
            end
        end
        #1;
        chk("A", A, m_A);
        chk("B", B, m_B);
        chk("C", C, m_C);
        chk("op_valid", op_valid, m_opv);
        chk("sync_err", sync_err, m_serr);
        chk("triple_cnt", triple_cnt, m_cnt);
`ifdef MAC_FEEDER_PARITY_EN
        chk("par_err", par_err, m_perr);
        if (par_err) perr_cnt++;
`endif
        if (op_valid) got_q.push_back({A, B, C});
        if (sync_err) serr_cnt++;
    endtask

    task automatic restart();
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        got_q.delete();
        serr_cnt = 0;
        perr_cnt = 0;
    endtask

    typedef struct {
        logic        rst; logic v; logic [7:0] d;
        logic        rdy; logic [7:0] a, b, c; logic opv; logic [15:0] cnt;
    } vec_t;
    vec_t tbl[15];

    logic [7:0] hb[9];
    int idx;
    bit saw_stall;

    initial begin
        // rst v d | rdy A B C opv cnt  (rdy sampled before the edge, rest after)
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h03, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 8'h04, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'h05, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 8'h04, 8'h05, 1'b1, 16'd1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 8'h04, 8'h05, 1'b0, 16'd1};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 1'b1, 8'h10, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, 1'b1, 8'h02, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
        tbl[9]  = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
        tbl[10] = '{1'b0, 1'b1, 8'h20, 1'b1, 8'h10, 8'h02, 8'h01, 1'b1, 16'd1};
        tbl[11] = '{1'b0, 1'b1, 8'h03, 1'b1, 8'h10, 8'h02, 8'h01, 1'b0, 16'd1};
        tbl[12] = '{1'b0, 1'b1, 8'h07, 1'b1, 8'h10, 8'h02, 8'h01, 1'b0, 16'd1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 8'h03, 8'h07, 1'b1, 16'd2};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 8'h03, 8'h07, 1'b0, 16'd2};

        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            tick(tbl[i].d, tbl[i].v, 1'b0, 1'b0, tbl[i].rst);
            chk($sformatf("vec%0d_rdy", i), dut_rdy, tbl[i].rdy);
            chk($sformatf("vec%0d_abc", i), {A, B, C}, {tbl[i].a, tbl[i].b, tbl[i].c});
            chk($sformatf("vec%0d_opv", i), op_valid, tbl[i].opv);
            chk($sformatf("vec%0d_cnt", i), triple_cnt, tbl[i].cnt);
            if (i == 5) chk("mac_result", mac_q, 32'h11);
        end

        // hold for 8 cycles while 9 bytes are offered
        restart();
        for (int i = 0; i < 9; i++) hb[i] = 8'h21 + 8'(i);
        idx = 0;
        saw_stall = 0;
        for (int c = 0; c < 40 && idx < 9; c++) begin
            tick(hb[idx], 1'b1, 1'b0, c < 8, 1'b0);
            if (c < 8 && !dut_rdy) saw_stall = 1;
            if (c == 7) chk("hold_frozen", {A, B, C, 7'd0, op_valid}, 32'h0);
            if (cur_acc) idx++;
        end
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_stall", saw_stall, 1);
        chk("hold_ntrip", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("hold_t0", got_q[0], 24'h212223);
            chk("hold_t1", got_q[1], 24'h242526);
            chk("hold_t2", got_q[2], 24'h272829);
        end
        chk("hold_cnt", triple_cnt, 3);

        // resync with in_sof mid-frame
        restart();
        tick(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'hBB, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sof_serr", serr_cnt, 1);
        chk("sof_ntrip", got_q.size(), 1);
        if (got_q.size() == 1) chk("sof_trip", got_q[0], 24'h112233);

        // reset after an accepted B byte
        restart();
        tick(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_ntrip", got_q.size(), 1);
        if (got_q.size() == 1) chk("rst_trip", got_q[0], 24'h010203);
        chk("rst_cnt", triple_cnt, 1);

`ifdef MAC_FEEDER_PARITY_EN
        // bad parity on 0x06; 0x08 carries in_sof to realign the frame
        restart();
        tick(8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        bad_par = 1;
        tick(8'h06, 1'b1, 1'b0, 1'b0, 1'b0);
        bad_par = 0;
        tick(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h08, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h0A, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("par_perr", perr_cnt, 1);
        chk("par_ntrip", got_q.size(), 1);
        if (got_q.size() == 1) chk("par_trip", got_q[0], 24'h08090A);
`endif

        // random traffic against the model
        restart();
        for (int i = 0; i < 1500; i++) begin
`ifdef MAC_FEEDER_PARITY_EN
            bad_par = ($urandom % 8) == 0;
`endif
            tick(8'($urandom), ($urandom % 4) != 0, ($urandom % 10) == 0,
                 ($urandom % 4) == 0, ($urandom % 64) == 0);
        end
        bad_par = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
Upstream stage of the 8-bit multiply-accumulate register (DATA_OUT = A*B + C). It takes a serial byte stream with a valid/ready handshake and assembles each group of three bytes into an {A, B, C} operand triple. It buffers one completed triple and presents A/B/C as stable registered outputs. Each new triple is marked with a one-cycle op_valid pulse, so the MAC register result that follows is one cycle later.

Parameters:
DATA_W, 8, width of each operand byte and of A/B/C
CNT_W, 16, width of triple_cnt

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_data  in  DATA_W  serial operand byte; order is A, B, C
in_valid  in  1  in_data is valid this cycle
in_ready  out  1  feeder accepts in_data this cycle
in_sof  in  1  marks the current byte as an A byte (frame start / resync)
hold  in  1  downstream hold; while high, the A/B/C outputs are frozen
A  out  DATA_W  operand A, registered
B  out  DATA_W  operand B, registered
C  out  DATA_W  operand C, registered
op_valid  out  1  one-cycle pulse; A/B/C changed on this edge
sync_err  out  1  one-cycle pulse; a partial triple was discarded by in_sof
triple_cnt  out  CNT_W  number of triples issued, wraps

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, and sampled on the rising edge.
- Values while reset is high: A=B=C=0, op_valid=0, sync_err=0, triple_cnt=0, in_ready=0, state=WAIT_A, pend_full=0, staging registers a_s=b_s=0.
- Reset asserted mid-frame discards the partial triple and any pending triple. No op_valid is issued for them.
- Accept condition: acc = in_valid & in_ready.
- in_ready is combinational: in_ready = !reset & !(state==WAIT_C & pend_full). A C byte is refused only while the buffer still holds an undelivered triple.
- State machine (three states):
  - WAIT_A: on acc, a_s <= in_data, go to WAIT_B.
  - WAIT_B: on acc, b_s <= in_data, go to WAIT_C.
  - WAIT_C: on acc, pending triple <= {a_s, b_s, in_data}, pend_full <= 1, go to WAIT_A.
- Resync: on acc with in_sof=1 while state is WAIT_B or WAIT_C:
  - the byte is taken as A: a_s <= in_data, go to WAIT_B;
  - the partial triple is dropped;
  - sync_err pulses for 1 cycle.
  - in_sof in WAIT_A is normal, no error. in_sof=0 in WAIT_A is allowed; resync is optional.
- Output update: on a cycle where pend_full=1 and hold=0:
  - {A, B, C} <= pending triple, pend_full <= 0;
  - op_valid = 1 in the following cycle;
  - triple_cnt increments, wrapping from 2^CNT_W-1 to 0.
- Simultaneous load and drain: a C accept and a drain on the same edge cannot both happen, because in_ready=0 whenever pend_full=1 in WAIT_C.
- Latency: a C byte accepted at edge N sets pend_full. With hold=0, A/B/C update at edge N+1 and op_valid is high during cycle N+1..N+2. The MAC register result is valid one edge after that.
- Throughput: one triple per 3 accepted bytes, with no bubbles when hold=0.
- hold=1: A/B/C, op_valid=0 and triple_cnt are frozen. Input keeps filling a_s/b_s, then stalls in WAIT_C until hold drops.
- Arithmetic: no arithmetic on operands; bytes pass through unmodified.

Optional Feature:
MAC_FEEDER_PARITY_EN
- Defined:
  - adds input in_parity (1 bit), odd parity over {in_data, in_parity};
  - on acc with a parity mismatch, the byte is dropped, state returns to WAIT_A, a_s/b_s are cleared, and output par_err pulses for 1 cycle;
  - the pending triple and the A/B/C outputs are unaffected.
- Not defined: the in_parity and par_err ports are absent, and every accepted byte is used.

Test Plan:
- Reset release, then bytes 0x03, 0x04, 0x05 with in_valid=1 and hold=0 -> A=0x03, B=0x04, C=0x05 one edge after the C accept; op_valid pulses once; triple_cnt=1; the MAC register downstream shows 0x11 on the next edge.
- Stream 0x10, 0x02, 0x01, 0x20, 0x03, 0x07 back-to-back -> two op_valid pulses 3 cycles apart; final A=0x20, B=0x03, C=0x07; triple_cnt=2.
- hold=1 for 8 cycles, stream 9 bytes -> in_ready drops in WAIT_C after the first triple completes, A/B/C stay at their reset values; after hold=0 the triples are delivered in order, none lost, triple_cnt=3.
- Bytes 0xAA, 0xBB, then 0x11 with in_sof=1, then 0x22, 0x33 -> sync_err pulses once; output triple is {0x11, 0x22, 0x33}; 0xAA and 0xBB never appear on A/B/C.
- Reset asserted after an accepted B byte, then 0x01, 0x02, 0x03 -> no op_valid from the partial triple; next output is {0x01, 0x02, 0x03}; triple_cnt=1.
- MAC_FEEDER_PARITY_EN defined, bad parity on the 2nd byte of 0x05, 0x06, 0x07 followed by 0x08, 0x09, 0x0A -> par_err pulses once; the only triple issued is {0x08, 0x09, 0x0A}.
